serial_subtract: RTL and testbench

SERIAL_SUBTRACT -- requirements
Module: serial_subtract

---
 rtl/serial_subtract_pkg.sv | 10 +
 rtl/serial_subtract_fullsubtract.sv | 13 +
 rtl/serial_subtract.sv | 107 ++++++++++
 tb/tb_serial_subtract.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtract_pkg.sv
// rtl/serial_subtract_pkg.sv - shared state encoding for serial arithmetic stages
package serial_subtract_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtract_fullsubtract.sv
// rtl/serial_subtract_fullsubtract.sv - one-bit full subtractor
module fullSubtract (
  input  logic A,
  input  logic B,
  input  logic bIn,
  output logic D,
  output logic bOut
);

  assign D    = A ^ B ^ bIn;
  assign bOut = (~A & B) | (~(A ^ B) & bIn);

endmodule

// File: rtl/serial_subtract.sv
// rtl/serial_subtract.sv - bit-serial subtractor, LSB first, one bit per clock
module serial_subtract
  import serial_subtract_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bOut
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             diff_bit;
  logic             br_next;
  logic             last_bit;

  fullSubtract u_bit (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .bIn  (br_q),
    .D    (diff_bit),
    .bOut (br_next)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The result register fills from the MSB so that after WIDTH shifts the LSB sits at bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      d     <= '0;
      bOut  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bIn;
            res_q <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {diff_bit, res_q[WIDTH-1:1]};
          br_q  <= br_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            d    <= {diff_bit, res_q[WIDTH-1:1]};
            bOut <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtract.sv
// tb/tb_serial_subtract.sv - scoreboard bench for serial_subtract
module tb_serial_subtract;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bIn;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bOut;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_d = '0;
  logic         last_b = 1'b0;

  serial_subtract #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bIn   (bIn),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bOut  (bOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks busy/done framing.
  initial begin
    forever begin
      @(negedge clk);
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) begin
        busy_cnt++;
        check("d_hold_in_shift", {24'd0, d}, {24'd0, last_d});
        check("bout_hold_in_shift", {31'd0, bOut}, {31'd0, last_b});
      end else if (!done) begin
        busy_cnt = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("d", {24'd0, d}, {24'd0, e.d});
          check("bout", {31'd0, bOut}, {31'd0, e.bo});
          check("done_cycle", cyc, e.cyc);
          check("busy_cycles", busy_cnt, W);
          last_d = e.d;
          last_b = e.bo;
        end
      end
    end
  end

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                    input logic [W-1:0] ed, input logic eb);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    bIn   = bi;
    e.d   = ed;
    e.bo  = eb;
    e.cyc = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bIn   = 1'($urandom);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) check("timeout_done", 0, 1);
  endtask

  initial begin
    logic [W:0] ref_v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbi;
    int           c0;
    int           dones;
    exp_t         e;

    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    bIn   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_d", {24'd0, d}, 0);
    check("rst_bout", {31'd0, bOut}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("no_start_under_reset", {31'd0, busy}, 0);

    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    op(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1);

    // start held high: accepts every W+2 cycles, a is disturbed while busy
    @(negedge clk);
    c0    = cyc;
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    bIn   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e.d   = 8'h0F;
      e.bo  = 1'b0;
      e.cyc = c0 + 1 + W + k * (W + 2);
      sb.push_back(e);
    end
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk);
      a = ((i % (W + 2)) inside {[1:6]}) ? 8'hAA : 8'h10;
      if (i == 3 * (W + 2) - 1) start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("held_start_all_done", sb.size(), 0);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    a     = 8'h37;
    b     = 8'h12;
    bIn   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    last_d = '0;
    last_b = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_d", {24'd0, d}, 0);
    check("abort_bout", {31'd0, bOut}, 0);
    dones = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    op(8'h37, 8'h12, 1'b0, 8'h25, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra    = W'($urandom);
      rb    = W'($urandom);
      rbi   = 1'($urandom);
      ref_v = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      op(ra, rb, rbi, ref_v[W-1:0], ref_v[W]);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
